// File: rtl/bt_status_tx.sv
// bt_status_tx
// Sends a 5-byte status message ("<mode>-<pos>\r\n") over an 8N1 UART line
// toward an HM-10 module whenever the registered {modo,posi} differs from
// the last value sent, or once after reset.
//
// Parameters
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : UART bit rate; one bit lasts CLK_HZ/BAUD clock cycles
// Ports
//   CLK    : system clock, rising edge
//   RESET  : asynchronous active-high reset
//   modo   : mode select, 0 = 'A', 1 = 'B'
//   posi   : servo position index, 0..4 -> '1'..'5', 5..7 -> '?'
//   tx     : UART serial output, idle high
//   busy   : high while a message is on the line
module bt_status_tx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       modo,
    input  logic [2:0] posi,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_next;

    logic             modo_p0;
    logic [2:0]       posi_p0;
    logic             snap_modo;
    logic [2:0]       snap_posi;
    logic             snap_vld;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_cnt;
    logic             baud_done;
    logic             trigger;
    logic [7:0]       cur_byte;

    // Message byte idx of the status line for a given snapshot.
    function automatic logic [7:0] msg_byte(input logic m, input logic [2:0] p,
                                            input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = m ? 8'h42 : 8'h41;
            3'd1:    b = 8'h2D;
            3'd2:    b = (p <= 3'd4) ? (8'h31 + {5'd0, p}) : 8'h3F;
            3'd3:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Stage p0: input capture; inputs are treated as synchronous to CLK
    always_ff @(posedge CLK) begin
        modo_p0 <= modo;
        posi_p0 <= posi;
    end

    // Only consulted in IDLE, so changes that revert mid-message are never seen.
    assign trigger   = !snap_vld || (modo_p0 != snap_modo) || (posi_p0 != snap_posi);
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (trigger) state_next = START;
            START: if (baud_done) state_next = DATA;
            DATA:  if (baud_done && (bit_cnt == 3'd7)) state_next = STOP;
            STOP:  if (baud_done) state_next = (byte_cnt == 3'd4) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            snap_modo <= 1'b0;
            snap_posi <= 3'd0;
            snap_vld  <= 1'b0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            if (trigger) begin
                snap_modo <= modo_p0;
                snap_posi <= posi_p0;
                snap_vld  <= 1'b1;
            end
        end else begin
            baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
            if (baud_done) begin
                // bit_cnt wraps 7 -> 0 on its own, ready for the next byte
                if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
                if (state == STOP) byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
            end
        end
    end

    // Bytes come from the snapshot only, so live inputs cannot disturb a frame.
    assign cur_byte = msg_byte(snap_modo, snap_posi, byte_cnt);

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bt_status_tx.sv
module tb_bt_status_tx;

    localparam int DIV     = 16;
    localparam int MSG_LEN = 50 * DIV;

    logic       clk;
    logic       rst;
    logic       modo;
    logic [2:0] posi;
    logic       tx;
    logic       busy;

    logic       rst_def;
    logic       tx_def;
    logic       busy_def;

    int tests  = 0;
    int failed = 0;

    bt_status_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .CLK   (clk),
        .RESET (rst),
        .modo  (modo),
        .posi  (posi),
        .tx    (tx),
        .busy  (busy)
    );

    bt_status_tx u_def (
        .CLK   (clk),
        .RESET (rst_def),
        .modo  (1'b0),
        .posi  (3'd0),
        .tx    (tx_def),
        .busy  (busy_def)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: message bytes straight from the character rules.
    function automatic logic [7:0] ref_byte(input logic m, input logic [2:0] p, input int idx);
        logic [7:0] b [5];
        b[0] = m ? 8'h42 : 8'h41;
        b[1] = 8'h2D;
        b[2] = (p < 5) ? 8'h31 + 8'(p) : 8'h3F;
        b[3] = 8'h0D;
        b[4] = 8'h0A;
        return b[idx];
    endfunction

    // Reference: line level t cycles after the first start bit begins.
    function automatic logic ref_tx(input logic m, input logic [2:0] p, input int t);
        int frame_pos;
        int bit_pos;
        logic [7:0] b;
        frame_pos = t / (10 * DIV);
        bit_pos   = (t % (10 * DIV)) / DIV;
        b = ref_byte(m, p, frame_pos);
        if (bit_pos == 0) return 1'b0;
        if (bit_pos == 9) return 1'b1;
        return b[bit_pos - 1];
    endfunction

    // Called at a negedge; expects the start bit to appear lat cycles later,
    // then checks every cycle of the message and the return to idle.
    task automatic expect_msg(input logic m, input logic [2:0] p, input int lat, input string name);
        int waited = 0;
        int bad_t  = -1;
        logic bad_tx = 1'b0;
        logic bad_busy = 1'b0;
        while (tx !== 1'b0 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (tx !== 1'b0) begin
            failed++;
            $display("FAIL %s_start: tx=%b after %0d cycles, required start bit", name, tx, waited);
            return;
        end
        tests++;
        if (waited != lat) begin
            failed++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, waited, lat);
        end
        for (int t = 0; t < MSG_LEN; t++) begin
            if (t > 0) @(negedge clk);
            if (bad_t < 0 && (tx !== ref_tx(m, p, t) || busy !== 1'b1)) begin
                bad_t = t;
                bad_tx = tx;
                bad_busy = busy;
            end
        end
        tests++;
        if (bad_t >= 0) begin
            failed++;
            $display("FAIL %s_frame: cycle %0d tx=%b busy=%b, required tx=%b busy=1", name, bad_t,
                     bad_tx, bad_busy, ref_tx(m, p, bad_t));
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failed++;
            $display("FAIL %s_end: busy=%b tx=%b, required busy=0 tx=1", name, busy, tx);
        end
    endtask

    task automatic idle_check(input int n, input string name);
        int bad = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bad < 0 && (tx !== 1'b1 || busy !== 1'b0)) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            failed++;
            $display("FAIL %s: line active at idle cycle %0d, required tx=1 busy=0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rst_def = 1'b1;
        modo = 1'b0;
        posi = 3'd0;
        repeat (5) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin
            failed++;
            $display("FAIL reset_tx: got %b, required 1", tx);
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        rst = 1'b0;
        expect_msg(1'b0, 3'd0, 1, "reset_release");
    endtask

    task automatic test_idle_hold();
        idle_check(300, "idle_hold");
    endtask

    task automatic test_mode_b();
        modo = 1'b1;
        posi = 3'd3;
        // one edge to register the inputs, one for the FSM to leave IDLE
        expect_msg(1'b1, 3'd3, 2, "mode_b");
    endtask

    task automatic test_pos_unknown();
        modo = 1'b0;
        posi = 3'd6;
        expect_msg(1'b0, 3'd6, 2, "pos_unknown");
    endtask

    task automatic test_revert_then_change();
        posi = 3'd1;
        fork
            expect_msg(1'b0, 3'd1, 2, "snap1");
            begin
                repeat (100 + $urandom_range(0, 50)) @(negedge clk);
                posi = 3'd2;
                repeat (100 + $urandom_range(0, 50)) @(negedge clk);
                posi = 3'd1;
                repeat (100 + $urandom_range(0, 50)) @(negedge clk);
                posi = 3'd4;
            end
        join
        expect_msg(1'b0, 3'd4, 1, "followup");
        idle_check(100, "single_followup");
    endtask

    task automatic test_revert_only();
        posi = 3'd2;
        fork
            expect_msg(1'b0, 3'd2, 2, "revert_msg");
            begin
                repeat (200 + $urandom_range(0, 100)) @(negedge clk);
                modo = 1'b1;
                posi = 3'd7;
                repeat (200 + $urandom_range(0, 100)) @(negedge clk);
                modo = 1'b0;
                posi = 3'd2;
            end
        join
        idle_check(100, "revert_no_msg");
    endtask

    task automatic test_random(input logic cm_in, input logic [2:0] cp_in);
        logic cm;
        logic [2:0] cp;
        logic m;
        logic [2:0] p;
        cm = cm_in;
        cp = cp_in;
        for (int i = 0; i < 6; i++) begin
            do begin
                m = 1'($urandom_range(0, 1));
                p = 3'($urandom_range(0, 7));
            end while (m == cm && p == cp);
            modo = m;
            posi = p;
            expect_msg(m, p, 2, "random");
            cm = m;
            cp = p;
            idle_check($urandom_range(1, 20), "random_gap");
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        modo = ~modo;
        @(negedge clk);
        while (tx !== 1'b0 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        // land inside the data bits of byte 2
        repeat (10 * DIV + DIV + $urandom_range(0, 7 * DIV - 1)) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL reset_mid_busy_before: got %b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_async: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_hold: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
        end
        rst = 1'b0;
        expect_msg(modo, posi, 1, "reset_mid_fresh");
    endtask

    task automatic test_default_baud();
        int waited = 0;
        int low = 0;
        @(negedge clk);
        rst_def = 1'b0;
        while (tx_def !== 1'b0 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        while (tx_def === 1'b0 && low < 6000) begin
            @(negedge clk);
            low++;
        end
        tests++;
        if (low != 5208) begin
            failed++;
            $display("FAIL default_bit_period: got %0d cycles, required 5208", low);
        end
        tests++;
        if (busy_def !== 1'b1) begin
            failed++;
            $display("FAIL default_busy: got %b, required 1", busy_def);
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_mode_b();
        test_pos_unknown();
        test_revert_then_change();
        test_revert_only();
        test_random(1'b0, 3'd2);
        test_reset_mid();
        test_default_baud();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
